comp_phase_det: RTL and testbench
=================================

Name: comp_phase_det

Overview:
- Sits directly downstream of the ADC sign comparator in the PLL loop and consumes its 1-bit ADC_comp square wave.
- Deglitches ADC_comp and measures its period in clk cycles.
- Measures the signed phase error between ADC_comp rising edges and rising edges of the NCO reference square wave.
- Publishes period, phase_err and a lock indicator to the loop filter.

Parameters:
- DEB_LEN, 4: consecutive equal ADC_comp samples required before the filtered level changes (range 2..15).
- CNT_W, 16: width of the period and phase counters and outputs.
- MIN_PERIOD, 16: shortest accepted period in cycles; shorter periods are rejected.
- MAX_PERIOD, 4095: longest accepted period and phase-count timeout (must be < 2^(CNT_W-1)).
- LOCK_TOL, 8: magnitude of |phase_err| counted as in-lock.
- LOCK_CNT, 16: consecutive in-lock phase measurements required to assert locked.

Ports:
- clk  in  1  system clock.
- nrst  in  1  synchronous reset, active-high (asserted = 1).
- swiptAlive  in  1  link alive; 0 acts exactly as reset.
- ADC_comp  in  1  comparator output, synchronous to clk.
- ref_in  in  1  NCO reference square wave, synchronous to clk.
- period  out  CNT_W  last accepted ADC_comp period in cycles.
- period_valid  out  1  one-cycle strobe, period updated.
- phase_err  out  CNT_W  signed two's complement; positive = ADC_comp leads ref_in.
- phase_valid  out  1  one-cycle strobe, phase_err updated.
- locked  out  1  loop in lock.
- timeout  out  1  one-cycle strobe, no matching edge within MAX_PERIOD.

Behaviour:
- Reset (nrst=1 or swiptAlive=0, sampled at posedge):
  - All outputs 0.
  - Filter state 0; all counters 0; FSM IDLE.
  - Takes effect the same edge and aborts any measurement in progress.
- Deglitch filter:
  - comp_f changes to level L after DEB_LEN consecutive samples equal to L while comp_f != L; the run counter resets on any mismatch.
  - If ADC_comp first reads 1 at edge k (held high, comp_f=0), comp_f=1 after edge k+DEB_LEN-1.
- Edge detection:
  - c_rise = comp_f & ~comp_f_d.
  - ref_in passes through a DEB_LEN-1 stage delay line, then r_rise = ref_dly & ~ref_dly_d.
  - Both paths therefore have equal latency.
- Period counter:
  - Increments every cycle and saturates at MAX_PERIOD.
  - On c_rise it loads 1.
  - On c_rise with count in [MIN_PERIOD, MAX_PERIOD-1]: period <= count, period_valid=1 in the next cycle.
  - On c_rise with count outside that range: no strobe.
  - The first c_rise after reset never produces a strobe.
- Phase FSM (IDLE, COMP_LEAD, REF_LEAD; phase counter pc):
  - IDLE, c_rise & r_rise in the same cycle: phase_err=0, phase_valid, stay IDLE.
  - IDLE, c_rise only: go to COMP_LEAD, pc=1.
  - IDLE, r_rise only: go to REF_LEAD, pc=1.
  - COMP_LEAD, r_rise: phase_err=+pc, phase_valid, go to IDLE.
  - COMP_LEAD, another c_rise: pc=1, stay COMP_LEAD (no output).
  - COMP_LEAD, r_rise and c_rise together: report +pc, then go to COMP_LEAD with pc=1.
  - REF_LEAD is symmetric: reports -pc on c_rise.
  - Any lead state with pc reaching MAX_PERIOD: timeout strobe, go to IDLE.
- Output timing: all strobes are registered and high exactly one cycle; phase_err and period hold between strobes.
- Lock logic:
  - Each phase_valid with |phase_err| <= LOCK_TOL increments the lock counter, saturating at LOCK_CNT.
  - When the counter equals LOCK_CNT, locked=1 in the next cycle.
  - A phase_valid with |phase_err| > LOCK_TOL, or any timeout, clears the counter and deasserts locked in the next cycle.
- Arithmetic: negation is two's complement in CNT_W bits. No overflow is possible because pc <= MAX_PERIOD < 2^(CNT_W-1).

Decomposition:
- Shared package pll_pkg holds:
  - FSM state encoding: PD_IDLE, PD_COMP_LEAD, PD_REF_LEAD.
  - Default CNT_W and MAX_PERIOD constants.
- One natural sub-module, comp_deglitch: the DEB_LEN run-length filter plus edge detector. Instantiate it for ADC_comp; the ref path uses the delay line only.

Test Plan:
- Reset and idle: hold nrst=1 for 5 cycles with ADC_comp toggling -> all outputs 0; after release with no edges, no strobes.
- Deglitch: high pulses of 3 cycles on ADC_comp (DEB_LEN=4) -> comp_f stays 0, no c_rise; a 4-cycle pulse -> exactly one c_rise.
- Period: ADC_comp square wave of 100 cycles (50/50), ref_in identical -> period=100 on every strobe from the 2nd edge; phase_err=0; locked=1 after the 16th phase_valid.
- Phase sign: ref_in delayed by 7 cycles -> phase_err=+7 each period. ref_in advanced by 12 cycles -> phase_err=-12 (0xFFF4), locked drops on the first such strobe.
- Timeout: one ADC_comp edge then ref_in held 0 for 5000 cycles -> timeout pulse 4094 cycles after c_rise, FSM back in IDLE, locked=0.
- Mid-operation abort: swiptAlive=0 for one cycle while in COMP_LEAD -> all outputs 0 next cycle, no stale phase_valid afterwards; period with 10-cycle spacing (< MIN_PERIOD) -> no period_valid.

Source files
------------

// File: rtl/pll_pkg.sv
// Shared definitions for the PLL phase-detector slice: phase FSM encoding
// and default counter sizing.
package pll_pkg;

  localparam int unsigned PD_CNT_W      = 16;
  localparam int unsigned PD_MAX_PERIOD = 4095;

  typedef enum logic [1:0] {
    PD_IDLE      = 2'd0,
    PD_COMP_LEAD = 2'd1,
    PD_REF_LEAD  = 2'd2
  } pd_state_e;

endpackage

// File: rtl/comp_deglitch.sv
// Run-length deglitch filter for a 1-bit level plus rising-edge detector.
// The level only flips after DEB_LEN consecutive samples of the new value.
module comp_deglitch #(
  parameter int unsigned DEB_LEN = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic rise_o
);

  localparam logic [3:0] RUN_LAST = 4'(DEB_LEN - 1);

  logic       level_q, level_d;
  logic       level_dly_q;
  logic [3:0] run_q, run_d;

  always_comb begin
    run_d   = '0;
    level_d = level_q;
    if (din_i != level_q) begin
      if (run_q == RUN_LAST) begin
        level_d = din_i;
      end else begin
        run_d = run_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q     <= 1'b0;
      level_dly_q <= 1'b0;
      run_q       <= '0;
    end else begin
      level_q     <= level_d;
      level_dly_q <= level_q;
      run_q       <= run_d;
    end
  end

  assign rise_o = level_q & ~level_dly_q;

endmodule

// File: rtl/comp_phase_det.sv
// ADC comparator period / phase detector: deglitches ADC_comp, measures its
// period, measures signed phase against ref_in and tracks loop lock.
module comp_phase_det
  import pll_pkg::*;
#(
  parameter int unsigned DEB_LEN    = 4,
  parameter int unsigned CNT_W      = PD_CNT_W,
  parameter int unsigned MIN_PERIOD = 16,
  parameter int unsigned MAX_PERIOD = PD_MAX_PERIOD,
  parameter int unsigned LOCK_TOL   = 8,
  parameter int unsigned LOCK_CNT   = 16
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             swiptAlive,
  input  logic             ADC_comp,
  input  logic             ref_in,
  output logic [CNT_W-1:0] period,
  output logic             period_valid,
  output logic [CNT_W-1:0] phase_err,
  output logic             phase_valid,
  output logic             locked,
  output logic             timeout
);

  localparam int unsigned LW   = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] MINP = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] MAXP = CNT_W'(MAX_PERIOD);
  localparam logic [CNT_W-1:0] TOL  = CNT_W'(LOCK_TOL);
  localparam logic [LW-1:0]    LCNT = LW'(LOCK_CNT);

  logic rst;
  logic c_rise, r_rise;

  logic [DEB_LEN-1:0] ref_sh_q;
  logic               ref_dly_q;

  pd_state_e        state_q, state_d;
  logic [CNT_W-1:0] pc_q, pc_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;
  logic             seen_q, seen_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             pval_q, pval_d;
  logic [CNT_W-1:0] perr_q, perr_d;
  logic             phv_q, phv_d;
  logic             to_q, to_d;
  logic [LW-1:0]    lock_q, lock_d;
  logic             locked_q;
  logic [CNT_W-1:0] abs_err;

  assign rst = nrst | ~swiptAlive;

  comp_deglitch #(
    .DEB_LEN (DEB_LEN)
  ) u_comp_dg (
    .clk_i  (clk),
    .rst_i  (rst),
    .din_i  (ADC_comp),
    .rise_o (c_rise)
  );

  // DEB_LEN flops here (input sample + DEB_LEN-1 delay stages) match the
  // filter's sample-to-level latency so equal-phase inputs measure zero.
  assign r_rise = ref_sh_q[DEB_LEN-1] & ~ref_dly_q;

  always_comb begin
    pcnt_d   = pcnt_q;
    seen_d   = seen_q;
    period_d = period_q;
    pval_d   = 1'b0;
    if (c_rise) begin
      pcnt_d = ONE;
      seen_d = 1'b1;
      if (seen_q && (pcnt_q >= MINP) && (pcnt_q < MAXP)) begin
        period_d = pcnt_q;
        pval_d   = 1'b1;
      end
    end else if (pcnt_q != MAXP) begin
      pcnt_d = pcnt_q + ONE;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    perr_d  = perr_q;
    phv_d   = 1'b0;
    to_d    = 1'b0;
    unique case (state_q)
      PD_IDLE: begin
        if (c_rise && r_rise) begin
          perr_d = '0;
          phv_d  = 1'b1;
        end else if (c_rise) begin
          state_d = PD_COMP_LEAD;
          pc_d    = ONE;
        end else if (r_rise) begin
          state_d = PD_REF_LEAD;
          pc_d    = ONE;
        end
      end
      PD_COMP_LEAD: begin
        if (r_rise) begin
          perr_d = pc_q;
          phv_d  = 1'b1;
          if (c_rise) pc_d = ONE;
          else        state_d = PD_IDLE;
        end else if (c_rise) begin
          pc_d = ONE;
        end else if ((pc_q + ONE) == MAXP) begin
          to_d    = 1'b1;
          state_d = PD_IDLE;
          pc_d    = '0;
        end else begin
          pc_d = pc_q + ONE;
        end
      end
      PD_REF_LEAD: begin
        if (c_rise) begin
          perr_d = '0 - pc_q;
          phv_d  = 1'b1;
          if (r_rise) pc_d = ONE;
          else        state_d = PD_IDLE;
        end else if (r_rise) begin
          pc_d = ONE;
        end else if ((pc_q + ONE) == MAXP) begin
          to_d    = 1'b1;
          state_d = PD_IDLE;
          pc_d    = '0;
        end else begin
          pc_d = pc_q + ONE;
        end
      end
      default: begin
        state_d = PD_IDLE;
        pc_d    = '0;
      end
    endcase
  end

  // Lock counter moves on the same edge that publishes the phase result.
  always_comb begin
    abs_err = perr_d[CNT_W-1] ? ('0 - perr_d) : perr_d;
    lock_d  = lock_q;
    if (to_d) begin
      lock_d = '0;
    end else if (phv_d) begin
      if (abs_err <= TOL) begin
        if (lock_q != LCNT) lock_d = lock_q + LW'(1);
      end else begin
        lock_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_sh_q  <= '0;
      ref_dly_q <= 1'b0;
      state_q   <= PD_IDLE;
      pc_q      <= '0;
      pcnt_q    <= '0;
      seen_q    <= 1'b0;
      period_q  <= '0;
      pval_q    <= 1'b0;
      perr_q    <= '0;
      phv_q     <= 1'b0;
      to_q      <= 1'b0;
      lock_q    <= '0;
      locked_q  <= 1'b0;
    end else begin
      ref_sh_q  <= {ref_sh_q[DEB_LEN-2:0], ref_in};
      ref_dly_q <= ref_sh_q[DEB_LEN-1];
      state_q   <= state_d;
      pc_q      <= pc_d;
      pcnt_q    <= pcnt_d;
      seen_q    <= seen_d;
      period_q  <= period_d;
      pval_q    <= pval_d;
      perr_q    <= perr_d;
      phv_q     <= phv_d;
      to_q      <= to_d;
      lock_q    <= lock_d;
      locked_q  <= (lock_q == LCNT);
    end
  end

  assign period       = period_q;
  assign period_valid = pval_q;
  assign phase_err    = perr_q;
  assign phase_valid  = phv_q;
  assign locked       = locked_q;
  assign timeout      = to_q;

endmodule

// File: tb/tb_comp_phase_det.sv
// Directed bench for comp_phase_det: reset, deglitch, period/lock, phase
// sign, timeout, abort and period bounds, with hand-derived expectations.
module tb_comp_phase_det;

  logic        clk = 1'b0;
  logic        nrst, swiptAlive, ADC_comp, ref_in;
  logic [15:0] period, phase_err;
  logic        period_valid, phase_valid, locked, timeout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  comp_phase_det #(
    .DEB_LEN    (4),
    .CNT_W      (16),
    .MIN_PERIOD (16),
    .MAX_PERIOD (4095),
    .LOCK_TOL   (8),
    .LOCK_CNT   (16)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .swiptAlive   (swiptAlive),
    .ADC_comp     (ADC_comp),
    .ref_in       (ref_in),
    .period       (period),
    .period_valid (period_valid),
    .phase_err    (phase_err),
    .phase_valid  (phase_valid),
    .locked       (locked),
    .timeout      (timeout)
  );

  function automatic logic sq(input int n, input int per, input int hi);
    return (n % per) < hi;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    nrst = 1'b1; swiptAlive = 1'b1; ADC_comp = 1'b0; ref_in = 1'b0;
    repeat (3) tick();
    nrst = 1'b0;
  endtask

  task automatic test_reset();
    nrst = 1'b1; swiptAlive = 1'b1; ref_in = 1'b0;
    for (int i = 0; i < 5; i++) begin
      ADC_comp = (i % 2) == 0;
      ref_in   = (i % 2) == 1;
      tick();
      checks++;
      if ({period, period_valid, phase_err, phase_valid, locked, timeout} !== 36'h0) begin
        errors++;
        $display("FAIL reset_outputs i=%0d got per=%h pv=%b err=%h phv=%b lk=%b to=%b expected all 0",
                 i, period, period_valid, phase_err, phase_valid, locked, timeout);
      end
    end
    nrst = 1'b0; ADC_comp = 1'b0; ref_in = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      checks++;
      if ({period_valid, phase_valid, locked, timeout} !== 4'b0000) begin
        errors++;
        $display("FAIL idle_quiet i=%0d got pv=%b phv=%b lk=%b to=%b expected 0",
                 i, period_valid, phase_valid, locked, timeout);
      end
    end
  endtask

  // 3-cycle pulses must be swallowed; the lone ref rise then leads the
  // 4-cycle pulse by 10 cycles, giving exactly one report of -10.
  task automatic test_deglitch();
    logic exp_phv;
    do_reset();
    for (int n = 0; n <= 80; n++) begin
      ADC_comp = ((n < 32) && ((n % 8) < 3)) || ((n >= 50) && (n < 54));
      ref_in   = (n >= 40);
      tick();
      exp_phv = (n == 54);
      checks++;
      if (phase_valid !== exp_phv || timeout !== 1'b0) begin
        errors++;
        $display("FAIL deglitch_strobe n=%0d got phv=%b to=%b expected phv=%b to=0",
                 n, phase_valid, timeout, exp_phv);
      end
      if (exp_phv) begin
        checks++;
        if (phase_err !== 16'hFFF6) begin
          errors++;
          $display("FAIL deglitch_phase n=%0d got %h expected fff6", n, phase_err);
        end
      end
    end
  endtask

  task automatic test_period_lock();
    logic exp_pv, exp_phv, exp_lk;
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      ADC_comp = sq(n, 100, 50);
      ref_in   = sq(n, 100, 50);
      tick();
      exp_pv  = ((n % 100) == 4) && (n >= 104);
      exp_phv = ((n % 100) == 4);
      exp_lk  = (n >= 1505);
      checks++;
      if (period_valid !== exp_pv || phase_valid !== exp_phv || locked !== exp_lk) begin
        errors++;
        $display("FAIL period_lock_flags n=%0d got pv=%b phv=%b lk=%b expected pv=%b phv=%b lk=%b",
                 n, period_valid, phase_valid, locked, exp_pv, exp_phv, exp_lk);
      end
      if (exp_pv) begin
        checks++;
        if (period !== 16'd100) begin
          errors++;
          $display("FAIL period_value n=%0d got %0d expected 100", n, period);
        end
      end
      if (exp_phv) begin
        checks++;
        if (phase_err !== 16'h0000) begin
          errors++;
          $display("FAIL phase_zero n=%0d got %h expected 0000", n, phase_err);
        end
      end
    end
  endtask

  // ref lags by 7 until n=2060, then leads by 12; lock is lost on the
  // first -12 report.
  task automatic test_phase_sign();
    logic        exp_phv, exp_lk;
    logic [15:0] exp_err;
    do_reset();
    for (int n = 0; n <= 2210; n++) begin
      ADC_comp = sq(n, 100, 50);
      if (n < 2060) ref_in = (n >= 7) && sq(n - 7, 100, 50);
      else          ref_in = sq(n + 12, 100, 50);
      tick();
      exp_phv = (n < 2060) ? ((n % 100) == 11) : ((n >= 2104) && ((n % 100) == 4));
      exp_err = (n < 2060) ? 16'd7 : 16'hFFF4;
      exp_lk  = (n >= 1512) && (n < 2105);
      checks++;
      if (phase_valid !== exp_phv || locked !== exp_lk) begin
        errors++;
        $display("FAIL phase_sign_flags n=%0d got phv=%b lk=%b expected phv=%b lk=%b",
                 n, phase_valid, locked, exp_phv, exp_lk);
      end
      if (exp_phv) begin
        checks++;
        if (phase_err !== exp_err) begin
          errors++;
          $display("FAIL phase_sign_value n=%0d got %h expected %h", n, phase_err, exp_err);
        end
      end
    end
  endtask

  task automatic test_timeout();
    logic exp_to, exp_phv;
    do_reset();
    for (int n = 0; n <= 4330; n++) begin
      ADC_comp = (n < 4200) || (n >= 4310);
      ref_in   = (n >= 4300);
      tick();
      exp_to  = (n == 4098);
      exp_phv = (n == 4314);
      checks++;
      if (timeout !== exp_to || phase_valid !== exp_phv || period_valid !== 1'b0 || locked !== 1'b0) begin
        errors++;
        $display("FAIL timeout_flags n=%0d got to=%b phv=%b pv=%b lk=%b expected to=%b phv=%b pv=0 lk=0",
                 n, timeout, phase_valid, period_valid, locked, exp_to, exp_phv);
      end
      if (exp_phv) begin
        checks++;
        if (phase_err !== 16'hFFF6) begin
          errors++;
          $display("FAIL timeout_idle_phase n=%0d got %h expected fff6", n, phase_err);
        end
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    for (int n = 0; n <= 500; n++) begin
      swiptAlive = (n != 306);
      ADC_comp   = (n < 306) && sq(n, 100, 50);
      ref_in     = (n >= 7) && sq(n - 7, 100, 50);
      tick();
      if (n == 305) begin
        checks++;
        if (period !== 16'd100 || phase_err !== 16'd7) begin
          errors++;
          $display("FAIL abort_pre n=%0d got per=%0d err=%h expected per=100 err=0007",
                   n, period, phase_err);
        end
      end else if (n == 306) begin
        checks++;
        if ({period, period_valid, phase_err, phase_valid, locked, timeout} !== 36'h0) begin
          errors++;
          $display("FAIL abort_clear n=%0d got per=%h pv=%b err=%h phv=%b lk=%b to=%b expected all 0",
                   n, period, period_valid, phase_err, phase_valid, locked, timeout);
        end
      end else if (n > 306) begin
        checks++;
        if ({period_valid, phase_valid, timeout} !== 3'b000) begin
          errors++;
          $display("FAIL abort_stale n=%0d got pv=%b phv=%b to=%b expected 0",
                   n, period_valid, phase_valid, timeout);
        end
      end
    end
  endtask

  task automatic test_period_bounds();
    int   pers [3] = '{10, 16, 15};
    int   his  [3] = '{5, 8, 8};
    logic exp_pv;
    for (int c = 0; c < 3; c++) begin
      do_reset();
      for (int n = 0; n < 100; n++) begin
        ADC_comp = sq(n, pers[c], his[c]);
        tick();
        exp_pv = (pers[c] >= 16) && ((n % pers[c]) == 4) && (n >= pers[c] + 4);
        checks++;
        if (period_valid !== exp_pv) begin
          errors++;
          $display("FAIL period_bound per=%0d n=%0d got pv=%b expected %b",
                   pers[c], n, period_valid, exp_pv);
        end
        if (exp_pv) begin
          checks++;
          if (period !== 16'(pers[c])) begin
            errors++;
            $display("FAIL period_bound_value per=%0d n=%0d got %0d expected %0d",
                     pers[c], n, period, pers[c]);
          end
        end
      end
    end
  endtask

  initial begin
    nrst = 1'b1; swiptAlive = 1'b1; ADC_comp = 1'b0; ref_in = 1'b0;
    test_reset();
    test_deglitch();
    test_period_lock();
    test_phase_sign();
    test_timeout();
    test_abort();
    test_period_bounds();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired: simulation did not complete");
    $fatal(1);
  end

endmodule
